// File: rtl/sdram_pkg.sv
// Shared SDRAM types: command encodings, init-sequencer states and address constants.
package sdram_pkg;

    localparam int unsigned SDRAM_A_W  = 13;
    localparam int unsigned SDRAM_BA_W = 2;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_INHIBIT   = 4'b1111,
        CMD_NOP       = 4'b0111,
        CMD_ACTIVE    = 4'b0011,
        CMD_READ      = 4'b0101,
        CMD_WRITE     = 4'b0100,
        CMD_PRECHARGE = 4'b0010,
        CMD_REFRESH   = 4'b0001,
        CMD_LOAD_MODE = 4'b0000
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_PRE,
        ST_PRE_W,
        ST_REF,
        ST_REF_W,
        ST_MRS,
        ST_MRS_W,
        ST_DONE
    } sdram_init_state_t;

    // A10 high on PRECHARGE selects all banks
    localparam logic [SDRAM_A_W-1:0] SDRAM_A10_ALL = 13'h0400;

endpackage

// File: rtl/sdram_init_if.sv
// Command-bus bundle between the init sequencer and the controller/bus mux.
interface sdram_init_if;
    import sdram_pkg::*;

    logic                  reinit;
    logic                  cke;
    sdram_cmd_t            cmd;
    logic [SDRAM_BA_W-1:0] ba;
    logic [SDRAM_A_W-1:0]  a;
    logic                  done;

    modport master (
        input  reinit,
        output cke, cmd, ba, a, done
    );

    modport slave (
        output reinit,
        input  cke, cmd, ba, a, done
    );

endinterface

// File: rtl/sdram_wait.sv
// Shared down-counter for SDRAM timing waits; ready is registered and asserts
// once the counter has reached zero, staying high until the next load.
module sdram_wait #(
    parameter int unsigned CNT_W   = 14,
    parameter int unsigned RST_VAL = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             ready
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= CNT_W'(RST_VAL);
            ready <= (RST_VAL == 0);
        end else if (load) begin
            cnt   <= value;
            ready <= (value == '0);
        end else begin
            cnt   <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
            ready <= (cnt <= CNT_W'(1));
        end
    end

endmodule

// File: rtl/sdram_init.sv
// SDRAM power-up initialisation sequencer: power-up wait, precharge-all,
// N_REF auto-refreshes, load-mode, then hands the bus over via done.
// Define SDRAM_INIT_FASTSIM_EN to shorten the power-up wait to one cycle.
module sdram_init
    import sdram_pkg::*;
#(
    parameter int unsigned          T_PWR = 10000,
    parameter int unsigned          T_RP  = 2,
    parameter int unsigned          T_RFC = 7,
    parameter int unsigned          T_MRD = 2,
    parameter int unsigned          N_REF = 8,
    parameter logic [SDRAM_A_W-1:0] MODE  = 13'h033,
    parameter int unsigned          CNT_W = 14
) (
    input  logic          clk,
    input  logic          reset,
    sdram_init_if.master  bus
);

`ifdef SDRAM_INIT_FASTSIM_EN
    localparam int unsigned T_PWR_EFF = 1;
`else
    localparam int unsigned T_PWR_EFF = T_PWR;
`endif

    localparam int unsigned REF_W = $clog2(N_REF + 1);

    // The counter is loaded on the edge leaving the command state, so a wait
    // of T cycles between commands needs T-2 further decrements.
    localparam logic [CNT_W-1:0] RP_LD  = (T_RP  >= 2) ? CNT_W'(T_RP  - 2) : '0;
    localparam logic [CNT_W-1:0] RFC_LD = (T_RFC >= 2) ? CNT_W'(T_RFC - 2) : '0;
    localparam logic [CNT_W-1:0] MRD_LD = (T_MRD >= 2) ? CNT_W'(T_MRD - 2) : '0;

    sdram_init_state_t state, state_d;

    logic             wait_load;
    logic [CNT_W-1:0] wait_value;
    logic             wait_ready;
    logic [REF_W-1:0] ref_cnt;
    logic             reinit_q;

    logic                  cke_d;
    sdram_cmd_t            cmd_d;
    logic [SDRAM_BA_W-1:0] ba_d;
    logic [SDRAM_A_W-1:0]  a_d;
    logic                  done_d;

    sdram_wait #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_PWR_EFF)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .value (wait_value),
        .ready (wait_ready)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_PWR;
        end else begin
            state <= state_d;
        end
    end

    // Refresh budget: armed in PRE, consumed one per REF
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
        end else if (state == ST_PRE) begin
            ref_cnt <= REF_W'(N_REF);
        end else if (state == ST_REF) begin
            ref_cnt <= ref_cnt - REF_W'(1);
        end
    end

    // reinit is only captured while done; anything else is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            reinit_q <= 1'b0;
        end else begin
            reinit_q <= bus.reinit && (state == ST_DONE);
        end
    end

    // Next-state and wait-counter control
    always_comb begin
        state_d    = state;
        wait_load  = 1'b0;
        wait_value = '0;

        case (state)
            ST_PWR: begin
                if (wait_ready) state_d = ST_PRE;
            end
            ST_PRE: begin
                wait_load  = 1'b1;
                wait_value = RP_LD;
                state_d    = (T_RP <= 1) ? ST_REF : ST_PRE_W;
            end
            ST_PRE_W: begin
                if (wait_ready) state_d = ST_REF;
            end
            ST_REF: begin
                wait_load  = 1'b1;
                wait_value = RFC_LD;
                if (T_RFC <= 1) begin
                    state_d = (ref_cnt <= REF_W'(1)) ? ST_MRS : ST_REF;
                end else begin
                    state_d = ST_REF_W;
                end
            end
            ST_REF_W: begin
                if (wait_ready) state_d = (ref_cnt == '0) ? ST_MRS : ST_REF;
            end
            ST_MRS: begin
                wait_load  = 1'b1;
                wait_value = MRD_LD;
                state_d    = (T_MRD <= 1) ? ST_DONE : ST_MRS_W;
            end
            ST_MRS_W: begin
                if (wait_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (reinit_q) state_d = ST_PRE;
            end
            default: state_d = ST_PWR;
        endcase
    end

    // Bus values decoded from the state being entered, so they register with it
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        a_d    = '0;
        done_d = 1'b0;

        case (state_d)
            ST_PWR:  cmd_d = CMD_INHIBIT;
            ST_PRE: begin
                cmd_d = CMD_PRECHARGE;
                a_d   = SDRAM_A10_ALL;
            end
            ST_REF:  cmd_d = CMD_REFRESH;
            ST_MRS: begin
                cmd_d = CMD_LOAD_MODE;
                a_d   = MODE;
            end
            ST_DONE: done_d = 1'b1;
            default: cmd_d = CMD_NOP;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cke  <= 1'b0;
            bus.cmd  <= CMD_INHIBIT;
            bus.ba   <= '0;
            bus.a    <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.cke  <= cke_d;
            bus.cmd  <= cmd_d;
            bus.ba   <= ba_d;
            bus.a    <= a_d;
            bus.done <= done_d;
        end
    end

endmodule

// File: doc/sdram_init.md
# sdram_init

Power-up initialisation sequencer for the SDRAM controller. After reset it drives the SDRAM command bus through the JEDEC start-up sequence: power-up wait, precharge-all, N auto-refreshes, and load-mode-register. It then asserts `done` so the controller's main scheduler takes over the bus. A `reinit` pulse re-runs the sequence from precharge, skipping the power-up wait.

## Interface
- `T_PWR`, 10000: power-up wait in clock cycles, with CKE high and command INHIBIT.
- `T_RP`, 2: cycles from PRECHARGE to the next command.
- `T_RFC`, 7: cycles from AUTO REFRESH to the next command.
- `T_MRD`, 2: cycles from LOAD MODE to `done`.
- `N_REF`, 8: number of AUTO REFRESH commands; must be ≥1.
- `MODE`, 13'h033: mode register value (burst 8, sequential, CAS 3).
- `CNT_W`, 14: wait-counter width; must hold max(T_*) − 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `reinit`  in  1  single-cycle request to re-run the sequence; honoured only while `done`.
- `cke`  out  1  SDRAM clock enable.
- `cmd`  out  4  {cs_n, ras_n, cas_n, we_n}.
- `ba`  out  2  bank address.
- `a`  out  13  address bus.
- `done`  out  1  initialisation complete; the controller owns the bus.

## Operation
- All outputs are registered.
- Reset values: `cke`=0, `cmd`=INHIBIT (4'b1111), `ba`=0, `a`=0, `done`=0, state PWR, wait counter loaded with T_PWR.
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, LOAD MODE 4'b0000.
- States and transitions:
  - PWR → PRE
  - PRE → PRE_W → REF
  - REF → REF_W → REF (while refreshes remain) or → MRS
  - MRS → MRS_W → DONE
  - DONE → PRE on `reinit`.
- Each command state issues its command for exactly one cycle and loads the wait counter. Its wait state outputs NOP until the counter reports ready.
- PRECHARGE drives `a[10]`=1 (all banks), other `a` bits 0, `ba`=0.
- LOAD MODE drives `a`=MODE, `ba`=0.
- All other cycles drive `a`=0, `ba`=0.
- The refresh counter is $clog2(N_REF+1) bits. It is loaded with N_REF in PRE and decremented on each REF. MRS follows when it reaches 0.
- In PWR: `cke`=1, `cmd`=INHIBIT. In every other state `cke`=1.
- DONE: `cmd`=NOP, `done`=1, held indefinitely.
- `reinit` outside DONE is ignored (not queued).
- `reset` in any state aborts immediately. Reset values appear after that edge and the full sequence restarts, including the power-up wait.
- Any T_* = 1 gives back-to-back commands with no NOP between them.

## Timing
- Edge 0 is the first rising edge with `reset` low. "At n" means the output value after edge n.
- INHIBIT with `cke`=1 at 0 … T_PWR−1.
- PRECHARGE at P = T_PWR.
- AUTO REFRESH k (k=0…N_REF−1) at P + T_RP + k·T_RFC.
- LOAD MODE at M = P + T_RP + N_REF·T_RFC.
- `done` rises at M + T_MRD.
- Defaults: PRE 10000, REF 10002 … 10051 in steps of 7, MRS 10058, `done` 10060.
- `reinit` sampled high at edge r while `done`: PRECHARGE and `done`=0 at r+1, then the same relative timing. `done` returns at r+1+T_RP+N_REF·T_RFC+T_MRD (r+61 with defaults).

## Configuration
- `SDRAM_INIT_FASTSIM_EN`:
  - Defined: effective power-up wait is 1 cycle regardless of T_PWR, so PRECHARGE is at 1. Intended for simulation only.
  - Undefined: T_PWR is used as given.

## Structure
- `sdram_pkg` holds:
  - `sdram_cmd_t` (4-bit packed enum: INHIBIT, NOP, PRECHARGE, REFRESH, LOAD_MODE, ACTIVE, READ, WRITE), shared with the controller and bus mux.
  - `sdram_init_state_t` state enum.
  - Constant `SDRAM_A10_ALL`.
- Sub-module `sdram_wait`: CNT_W down-counter with `load`, `value` and registered `ready`, instantiated once and reused by all wait states.

## Test plan
1. Release reset, defaults → `cke`=0/INHIBIT during reset; `cke`=1/INHIBIT for edges 0–9999; PRECHARGE with `a`=13'h0400 at 10000; NOP at 10001.
2. Continue → exactly 8 AUTO REFRESH at 10002+7k; NOP on every other cycle up to 10057.
3. Continue → LOAD MODE at 10058 with `a`=13'h033, `ba`=0; NOP at 10059; `done`=1 from 10060 with NOP held for 100 cycles.
4. Assert `reset` for 1 cycle at edge 10020 → `cke`=0, INHIBIT, `done`=0 after that edge; PRECHARGE reappears 10000 edges after release.
5. `reinit` at edge r after `done` → PRECHARGE at r+1, `done` low, `done` back at r+61. A second `reinit` at r+10 has no effect.
6. Compile with `SDRAM_INIT_FASTSIM_EN` → PRECHARGE at 1, `done` at 61.
